// File: rtl/m_condcode_serial.sv
// Digit-serial compare unit: resolves branch conditions and SLT/SLTU MSB-first, DW bits per cycle.
// Optional early termination on the first differing digit: define CONDCODE_SERIAL_EARLY_EXIT_EN.
module m_condcode_serial #(
    parameter int XLEN = 32,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_branch,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            result
);
    localparam int N  = XLEN / DW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] sa_reg, sa_next;
    logic [XLEN-1:0] sb_reg, sb_next;
    logic            lt_reg, lt_next;
    logic            gt_reg, gt_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            is_branch_reg, is_branch_next;
    logic [2:0]      func3_reg, func3_next;
    logic            done_reg, done_next;
    logic            result_reg, result_next;

    logic [DW-1:0]   digit_a, digit_b;
    logic            digit_lt, digit_gt;
    logic            lt_upd, gt_upd;
    logic            signed_in;
    logic            last_digit;

    function automatic logic cond_bit(input logic br, input logic [2:0] f3,
                                      input logic lt, input logic gt);
        logic eq;
        logic r;
        eq = ~lt & ~gt;
        r  = 1'b0;
        if (br) begin
            case (f3)
                3'b000:          r = eq;
                3'b001:          r = ~eq;
                3'b100, 3'b110:  r = lt;
                3'b101, 3'b111:  r = ~lt;
                default:         r = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b010, 3'b011:  r = lt;
                default:         r = 1'b0;
            endcase
        end
        return r;
    endfunction

    assign digit_a  = sa_reg[XLEN-1 -: DW];
    assign digit_b  = sb_reg[XLEN-1 -: DW];
    assign digit_lt = digit_a < digit_b;
    assign digit_gt = digit_a > digit_b;

    // The first differing digit decides; later digits cannot overturn it.
    assign lt_upd = lt_reg | (~lt_reg & ~gt_reg & digit_lt);
    assign gt_upd = gt_reg | (~lt_reg & ~gt_reg & digit_gt);

    assign signed_in = is_branch ? (func3 == 3'b100 || func3 == 3'b101)
                                 : (func3 == 3'b010);

`ifdef CONDCODE_SERIAL_EARLY_EXIT_EN
    assign last_digit = (cnt_reg == CW'(N - 1)) || (~lt_reg & ~gt_reg & (digit_lt | digit_gt));
`else
    assign last_digit = (cnt_reg == CW'(N - 1));
`endif

    always_comb begin
        state_next     = state_reg;
        sa_next        = sa_reg;
        sb_next        = sb_reg;
        lt_next        = lt_reg;
        gt_next        = gt_reg;
        cnt_next       = cnt_reg;
        is_branch_next = is_branch_reg;
        func3_next     = func3_reg;
        done_next      = 1'b0;
        result_next    = result_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sa_next        = a;
                    sb_next        = b;
                    // Flipping the sign bits maps two's complement order onto unsigned order.
                    if (signed_in) begin
                        sa_next[XLEN-1] = ~a[XLEN-1];
                        sb_next[XLEN-1] = ~b[XLEN-1];
                    end
                    is_branch_next = is_branch;
                    func3_next     = func3;
                    lt_next        = 1'b0;
                    gt_next        = 1'b0;
                    cnt_next       = '0;
                    state_next     = RUN;
                end
            end
            RUN: begin
                lt_next  = lt_upd;
                gt_next  = gt_upd;
                sa_next  = sa_reg << DW;
                sb_next  = sb_reg << DW;
                cnt_next = cnt_reg + CW'(1);
                if (last_digit) begin
                    cnt_next    = '0;
                    done_next   = 1'b1;
                    result_next = cond_bit(is_branch_reg, func3_reg, lt_upd, gt_upd);
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sa_reg        <= '0;
            sb_reg        <= '0;
            lt_reg        <= 1'b0;
            gt_reg        <= 1'b0;
            cnt_reg       <= '0;
            is_branch_reg <= 1'b0;
            func3_reg     <= 3'b000;
            done_reg      <= 1'b0;
            result_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sa_reg        <= sa_next;
            sb_reg        <= sb_next;
            lt_reg        <= lt_next;
            gt_reg        <= gt_next;
            cnt_reg       <= cnt_next;
            is_branch_reg <= is_branch_next;
            func3_reg     <= func3_next;
            done_reg      <= done_next;
            result_reg    <= result_next;
        end
    end

    assign busy   = (state_reg == RUN);
    assign done   = done_reg;
    assign result = result_reg;
endmodule

// File: tb/tb_m_condcode_serial.sv
// Directed self-checking bench for m_condcode_serial (XLEN 32, DW 8, four digit cycles).
module tb_m_condcode_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_branch = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy, done, result;

    int checks = 0;
    int errors = 0;

`ifdef CONDCODE_SERIAL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic        br;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
        int          lat;
        int          lat_ee;
    } vec_t;

    m_condcode_serial #(.XLEN(32), .DW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .is_branch(is_branch), .func3(func3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic br, input logic [2:0] f3, input logic [31:0] aa, input logic [31:0] bb);
        is_branch = br; func3 = f3; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        seen = 1'b0; cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                cyc = i; seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 1'b0) begin errors++; $display("FAIL reset_result got %b want 0", result); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_table_check(input vec_t v, input string tag, input int idx);
        int cyc; bit seen; int lat;
        lat = EE ? v.lat_ee : v.lat;
        launch(v.br, v.f3, v.a, v.b);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s[%0d] busy_after_accept got %b want 1", tag, idx, busy); end
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != lat) begin errors++; $display("FAIL %s[%0d] latency got %0d (seen %0d) want %0d", tag, idx, cyc, seen, lat); end
        checks++; if (result !== v.exp) begin errors++; $display("FAIL %s[%0d] result got %b want %b", tag, idx, result, v.exp); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || result !== v.exp) begin errors++; $display("FAIL %s[%0d] pulse_hold done %b result %b want 0 %b", tag, idx, done, result, v.exp); end
        $display("%s[%0d] func3=%b a=%h b=%h result=%b latency=%0d", tag, idx, v.f3, v.a, v.b, result, cyc);
    endtask

    task automatic test_branch();
        vec_t vb [6];
        vb[0] = '{1'b1, 3'b100, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4, 1};  // BLT: -1 < 0
        vb[1] = '{1'b1, 3'b110, 32'hFFFFFFFF, 32'h00000000, 1'b0, 4, 1};  // BLTU
        vb[2] = '{1'b1, 3'b111, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4, 1};  // BGEU
        vb[3] = '{1'b1, 3'b000, 32'h12345678, 32'h12345678, 1'b1, 4, 4};  // BEQ
        vb[4] = '{1'b1, 3'b001, 32'h12345678, 32'h12345678, 1'b0, 4, 4};  // BNE
        vb[5] = '{1'b1, 3'b101, 32'hFFFFFFFF, 32'h00000000, 1'b0, 4, 1};  // BGE
        for (int i = 0; i < 6; i++) run_table_check(vb[i], "branch", i);
    endtask

    task automatic test_slt();
        vec_t vs [3];
        vs[0] = '{1'b0, 3'b011, 32'h00000100, 32'h00000101, 1'b1, 4, 4};  // SLTU
        vs[1] = '{1'b0, 3'b010, 32'h80000000, 32'h7FFFFFFF, 1'b1, 4, 1};  // SLT
        vs[2] = '{1'b0, 3'b011, 32'h80000000, 32'h7FFFFFFF, 1'b0, 4, 1};  // SLTU, same operands
        for (int i = 0; i < 3; i++) run_table_check(vs[i], "slt", i);
    endtask

    task automatic test_overlap();
        int cyc; bit seen;
        is_branch = 1'b1; func3 = 3'b000; a = 32'h12345678; b = 32'h12345678; start = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overlap busy got %b want 1", busy); end
        // Keep start high and scramble operands while the first op is in flight.
        func3 = 3'b100; a = 32'h00000005; b = 32'h00000003;
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != 4) begin errors++; $display("FAIL overlap first_latency got %0d want 4", cyc); end
        checks++; if (result !== 1'b1) begin errors++; $display("FAIL overlap first_result got %b want 1", result); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL overlap second_accept busy %b done %b want 1 0", busy, done); end
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != 4) begin errors++; $display("FAIL overlap second_latency got %0d want 4", cyc); end
        checks++; if (result !== 1'b0) begin errors++; $display("FAIL overlap second_result got %b want 0", result); end
        $display("overlap first=1 second result=%b latency=%0d", result, cyc);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen;
        launch(1'b1, 3'b110, 32'hFFFFFFFF, 32'h00000000);
        wait_done(cyc, seen);
        checks++; if (!seen || result !== 1'b0) begin errors++; $display("FAIL b2b first_result got %b (seen %0d) want 0", result, seen); end
        // Request the next op while done is still high.
        is_branch = 1'b0; func3 = 3'b011; a = 32'h00000100; b = 32'h00000101; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b second_accept busy got %b want 1", busy); end
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != 4) begin errors++; $display("FAIL b2b second_latency got %0d want 4", cyc); end
        checks++; if (result !== 1'b1) begin errors++; $display("FAIL b2b second_result got %b want 1", result); end
        $display("back_to_back second result=%b latency=%0d", result, cyc);
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_run();
        int cyc; bit seen; int pulses;
        launch(1'b1, 3'b000, 32'hCAFEF00D, 32'hCAFEF00D);
        wait_done(cyc, seen);
        checks++; if (!seen || result !== 1'b1) begin errors++; $display("FAIL rst pre_result got %b want 1", result); end
        @(posedge clk); #1;
        launch(1'b1, 3'b000, 32'hCAFEF00D, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 1'b0) begin errors++; $display("FAIL rst abort busy %b done %b result %b want 0 0 0", busy, done, result); end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst no_done got %0d pulses want 0", pulses); end
        launch(1'b1, 3'b100, 32'hFFFFFFFF, 32'h00000000);
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != (EE ? 1 : 4)) begin errors++; $display("FAIL rst next_latency got %0d want %0d", cyc, EE ? 1 : 4); end
        checks++; if (result !== 1'b1) begin errors++; $display("FAIL rst next_result got %b want 1", result); end
        $display("rst_mid_run next result=%b latency=%0d", result, cyc);
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        int cyc; bit seen;
        launch(1'b1, 3'b010, 32'h00000000, 32'h00000001);
        wait_done(cyc, seen);
        checks++; if (!seen || result !== 1'b0) begin errors++; $display("FAIL illegal branch010 got %b want 0", result); end
        @(posedge clk); #1;
        launch(1'b0, 3'b011, 32'h00000000, 32'h00000001);
        wait_done(cyc, seen);
        checks++; if (!seen || result !== 1'b1) begin errors++; $display("FAIL illegal sltu_ref got %b want 1", result); end
        @(posedge clk); #1;
        launch(1'b0, 3'b110, 32'h00000000, 32'h00000001);
        wait_done(cyc, seen);
        checks++; if (!seen || result !== 1'b0) begin errors++; $display("FAIL illegal slt110 got %b want 0", result); end
        $display("illegal slt110 result=%b", result);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_slt();
        test_overlap();
        test_back_to_back();
        test_rst_mid_run();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m_condcode_serial.md
# m_condcode_serial

Parametrised multi-cycle compare unit producing branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) and SLT/SLTU results for midgetv.
- Compares two XLEN-bit operands MSB-first, one DW-bit digit per cycle, so the compare needs no full-width carry chain.
- Sits beside the ALU.
- Sequencer launches it with start.
- The registered result replaces the single-bit raluF/is_brcond path when narrow datapaths are built.

## Interface
- XLEN, 32, operand width.
- DW, 8, digit width. Must divide XLEN. N = XLEN/DW digit cycles. DW = XLEN gives N = 1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request. Accepted only when busy = 0.
- is_branch  in  1  1: branch semantics; 0: SLT semantics. Sampled at accept.
- func3  in  3  INSTR[14:12]. Sampled at accept.
- a  in  XLEN  rs1 operand. Sampled at accept.
- b  in  XLEN  rs2/immediate operand. Sampled at accept.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- result  out  1  branch-taken or SLT bit. Held until the next accept.

## Operation
- **States:** IDLE, RUN.
- **Accept** (start = 1 in IDLE):
  - Load shift registers sa/sb with a/b.
  - Latch is_branch and func3.
  - Clear lt, gt and the digit counter.
  - If the op is signed, invert bit XLEN-1 of both loaded operands; the signed compare then reduces to an unsigned compare.
  - Signed ops: branch func3 100/101; SLT func3 010.
  - Enter RUN.
- **RUN, each cycle:**
  - Compare the top digits sa[XLEN-1:XLEN-DW] and sb[...] unsigned.
  - If neither lt nor gt is set: set lt when digit_a < digit_b, set gt when digit_a > digit_b.
  - Shift sa and sb left by DW.
  - Increment the counter.
  - On the Nth digit, or on the early-exit condition (see Configuration), register the result, pulse done, and return to IDLE.
- **Result encoding.** eq = ~lt & ~gt over all processed digits. lt is signed or unsigned per op.
  - Branch: 000 eq; 001 ~eq; 100 lt; 101 ~lt; 110 lt; 111 ~lt; 010/011 give 0.
  - SLT: 010 lt (signed); 011 lt (unsigned); all others give 0.
- **Boundary conditions:**
  - start while busy: ignored; the operation in flight is unaffected.
  - start in the same cycle done is high: busy is already 0, so it is accepted and back-to-back ops are allowed.
  - rst mid-RUN: aborts; no done pulse.
  - Counter width: clog2(N), minimum 1 bit. It wraps only via reset or completion, never free-runs.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0; lt, gt and counter 0.
- Accept at edge k: busy = 1 from edge k.
- Digit j (1..N) is evaluated on edge k+j.
- Without early exit: done = 1 and result valid after edge k+N; busy = 0 at that edge.
- Latency start-to-done = N cycles; throughput one op per N cycles.
- result changes only on the completion edge or on reset. done is high for exactly one cycle.

## Configuration
- CONDCODE_SERIAL_EARLY_EXIT_EN defined:
  - RUN terminates on the edge where the first differing digit j sets lt or gt; done follows after edge k+j.
  - Equal operands still take N cycles.
- Undefined:
  - Always exactly N cycles. Latency is data-independent (constant-time).
  - The lt/gt update logic still freezes after the first difference.

## Test plan
All scenarios use XLEN = 32, DW = 8.
- BLT (branch, 100), a=0xFFFFFFFF, b=0x00000000 -> result 1. done after 4 cycles; after 1 cycle with EARLY_EXIT_EN.
- BLTU (110), same operands -> result 0 (gt), same latencies. BGEU (111) -> result 1.
- BEQ (000), a=b=0x12345678 -> result 1 after 4 cycles in both configurations. BNE (001) -> 0.
- SLTU (is_branch 0, 011), a=0x00000100, b=0x00000101 -> result 1 after 4 cycles in both configurations. SLT (010), a=0x80000000, b=0x7FFFFFFF -> 1.
- Back-to-back and overlap:
  - start held high through an op; operands changed mid-RUN -> first result unaffected.
  - A second op is accepted in the done cycle and completes N cycles later.
- Reset and illegal func3:
  - Assert rst on digit 2 -> busy 0, done never pulses, result 0.
  - Next op runs normally.
  - Branch with func3 010 -> result 0.
